eth_phy_10g_rx_lock_mon: RTL and testbench
==========================================

// Module: eth_phy_10g_rx_lock_mon
// PURPOSE
//  Multi-lane 64b/66b RX block-lock and BER monitor for the 10G/40G PHY RX path; one instance per PHY, N lanes.
//  Per lane: hunts sync-header alignment by driving SERDES bitslip, declares/loses block lock (802.3 cl.49 rules),
//  flags high BER per 125 us window, and requests a SERDES reset after repeated failed slips.
//  Sits between SERDES/gearbox header output and eth_phy_10g_rx descrambler/decoder; supersedes single-lane lock logic.
// PARAMETERS
//  LANES               1      number of independent 66b lanes (1..4)
//  HDR_WIDTH           2      sync header width per lane (fixed 2; parameter kept for port consistency)
//  BITSLIP_HIGH_CYCLES 1      cycles serdes_rx_bitslip held high per slip (>=1)
//  BITSLIP_LOW_CYCLES  8      cycles held low after each slip before hunting resumes (>=1)
//  COUNT_125US         19531  clk cycles per BER window (125 us @ 6.4 ns), >=2
//  MAX_SLIPS           132    consecutive slips without lock before reset request (>=1)
// PORTS
//  clk                  in   1               single clock, all logic
//  rst_n                in   1               asynchronous, active-low reset
//  serdes_rx_hdr        in   LANES*HDR_WIDTH lane i header at [i*2+:2]
//  serdes_rx_hdr_valid  in   LANES           header beat valid (gearbox gap = 0)
//  serdes_rx_bitslip    out  LANES           per-lane slip request to SERDES
//  serdes_rx_reset_req  out  LANES           1-cycle pulse: lane exhausted MAX_SLIPS
//  rx_block_lock        out  LANES           lane locked
//  rx_high_ber          out  LANES           lane high-BER flag
//  rx_ber_count         out  LANES*5         lane invalid-header count in current window, saturates at 16
//  rx_status            out  LANES           rx_block_lock & ~rx_high_ber
//  rx_all_lock          out  1               AND of rx_block_lock
// BEHAVIOUR
//  - Reset: every output 0; FSMs in HUNT; all counters 0; BER timer 0. Reset mid-slip drops bitslip immediately.
//  - Valid header = 2'b01 or 2'b10; only beats with hdr_valid=1 are evaluated; hdr_valid=0 freezes sh counters.
//  - All outputs registered: header at edge t reflected at edge t+1.
//  - Per-lane FSM (sh_cnt 7b, sh_inv_cnt 5b, slip_cnt 8b):
//    HUNT: valid beat -> sh_cnt++; invalid beat -> SLIP. sh_cnt reaches 64 (all valid) -> rx_block_lock=1,
//      slip_cnt=0, counters cleared -> LOCKED.
//    LOCKED: each beat sh_cnt++, invalid also sh_inv_cnt++. sh_inv_cnt reaches 16 -> rx_block_lock=0 -> SLIP
//      (same cycle as 16th bad header). sh_cnt reaches 64 with sh_inv_cnt<16 -> both cleared, stay LOCKED.
//    SLIP: bitslip=1 for BITSLIP_HIGH_CYCLES, then 0 for BITSLIP_LOW_CYCLES; headers ignored; then HUNT with
//      counters cleared. On SLIP entry slip_cnt++; if it reaches MAX_SLIPS: reset_req pulses 1 cycle, slip_cnt=0.
//  - BER: one shared free-running timer 0..COUNT_125US-1, wraps to 0.
//    While locked: invalid beat -> ber_cnt++ (sat 16); ber_cnt reaching 16 sets rx_high_ber immediately.
//    On wrap cycle: invalid beat on that cycle counts into closing window; rx_high_ber <= (final ber_cnt==16);
//      ber_cnt <= 0.
//    While not locked: ber_cnt=0, rx_high_ber=0.
//  - Lanes fully independent; simultaneous lock loss on several lanes permitted; no inter-lane deskew here.
// STRUCTURE
//  - Shared defs header (eth_phy_10g_defs.vh): SYNC_DATA=2'b10, SYNC_CTRL=2'b01, SH_LOCK_CNT=64,
//    SH_INV_LIMIT=16, BER_LIMIT=16, lock FSM state encodings.
//  - Sub-module eth_phy_10g_rx_lane_lock: one lane FSM + BER counter, instantiated LANES times via generate;
//    top holds shared BER timer, rx_all_lock reduction and port slicing.
// TESTING
//  1 LANES=2, lane0 aligned 01/10 headers -> rx_block_lock[0]=1 on the cycle after 64th valid beat; lane1 all 00
//    -> bitslip[1] high 1 cycle, low 8, repeats; reset_req[1] pulses after 132nd slip.
//  2 Locked lane, inject 15 bad headers in 64 -> stays locked; 16 bad in 64 -> lock drops next edge, bitslip 1.
//  3 COUNT_125US=200, 16 bad headers spread across one window (<16 per 64 block) -> rx_high_ber=1, rx_status=0;
//    next window with 3 bad -> high_ber clears at wrap.
//  4 16th bad header exactly on wrap cycle -> high_ber set and held through next window evaluation.
//  5 hdr_valid toggling 50% with good headers -> lock after exactly 64 valid beats, not 64 cycles.
//  6 Assert rst_n low mid-SLIP and while locked -> all outputs 0 asynchronously; re-hunt after release.

Source files
------------

// File: rtl/eth_phy_10g_rx_lock_mon_pkg.sv
// Shared definitions for the 64b/66b RX block-lock monitor.
//   - sync header codes, lock/BER thresholds
//   - per-lane lock FSM state encoding
//   - sh_valid(): classifies a 2-bit sync header as legal (01/10) or not
package eth_phy_10g_rx_lock_mon_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;

  localparam int SH_LOCK_CNT  = 64;  // beats per evaluation block
  localparam int SH_INV_LIMIT = 16;  // bad headers per block that break lock
  localparam int BER_LIMIT    = 16;  // bad headers per window that flag high BER

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_SLIP   = 2'd2
  } lock_state_t;

  function automatic logic sh_valid(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_phy_10g_rx_lane_lock.sv
// One lane of block-lock hunting plus its high-BER detector.
//   clk, rst_n   clock, asynchronous active-low reset
//   hdr          2-bit sync header for this lane
//   hdr_valid    header beat qualifier; there is no backpressure: a beat is
//                consumed on every clock edge where hdr_valid=1, and
//                hdr_valid=0 means "no beat" (all counters hold)
//   ber_wrap     1 on the last cycle of the shared BER window
//   bitslip      slip request to the SERDES
//   reset_req    1-cycle pulse when MAX_SLIPS consecutive slips found no lock
//   high_ber     lane high-BER flag
//   ber_count    invalid headers seen in the current window (saturating)
//   state_dbg    current lock FSM state (block lock == ST_LOCKED)
module eth_phy_10g_rx_lane_lock
  import eth_phy_10g_rx_lock_mon_pkg::*;
#(
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8,
  parameter int MAX_SLIPS           = 132
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  hdr,
  input  logic        hdr_valid,
  input  logic        ber_wrap,
  output logic        bitslip,
  output logic        reset_req,
  output logic        high_ber,
  output logic [4:0]  ber_count,
  output lock_state_t state_dbg
);

  localparam int SLIP_LEN = BITSLIP_HIGH_CYCLES + BITSLIP_LOW_CYCLES;
  localparam int TMR_W    = $clog2(SLIP_LEN + 1);

  lock_state_t      state, state_n;
  logic [6:0]       sh_cnt, sh_cnt_n;
  logic [4:0]       sh_inv_cnt, sh_inv_cnt_n;
  logic [7:0]       slip_cnt, slip_cnt_n;
  logic [TMR_W-1:0] tmr, tmr_n, tmr_inc;
  logic             bitslip_n, reset_req_n, enter_slip;
  logic [4:0]       ber_inc, ber_n;
  logic             high_ber_n;
  logic             hdr_ok;

  assign hdr_ok    = sh_valid(hdr);
  assign tmr_inc   = tmr + TMR_W'(1);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_HUNT;
      sh_cnt     <= '0;
      sh_inv_cnt <= '0;
      slip_cnt   <= '0;
      tmr        <= '0;
      bitslip    <= 1'b0;
      reset_req  <= 1'b0;
      ber_count  <= '0;
      high_ber   <= 1'b0;
    end else begin
      state      <= state_n;
      sh_cnt     <= sh_cnt_n;
      sh_inv_cnt <= sh_inv_cnt_n;
      slip_cnt   <= slip_cnt_n;
      tmr        <= tmr_n;
      bitslip    <= bitslip_n;
      reset_req  <= reset_req_n;
      ber_count  <= ber_n;
      high_ber   <= high_ber_n;
    end
  end

  always_comb begin
    state_n      = state;
    sh_cnt_n     = sh_cnt;
    sh_inv_cnt_n = sh_inv_cnt;
    slip_cnt_n   = slip_cnt;
    tmr_n        = tmr;
    bitslip_n    = bitslip;
    reset_req_n  = 1'b0;
    enter_slip   = 1'b0;

    case (state)
      ST_HUNT: begin
        if (hdr_valid) begin
          if (!hdr_ok) begin
            enter_slip = 1'b1;
          end else if (sh_cnt == 7'(SH_LOCK_CNT - 1)) begin
            state_n      = ST_LOCKED;
            sh_cnt_n     = '0;
            sh_inv_cnt_n = '0;
            slip_cnt_n   = '0;
          end else begin
            sh_cnt_n = sh_cnt + 7'd1;
          end
        end
      end
      ST_LOCKED: begin
        if (hdr_valid) begin
          if (!hdr_ok && (sh_inv_cnt == 5'(SH_INV_LIMIT - 1))) begin
            enter_slip = 1'b1;
          end else if (sh_cnt == 7'(SH_LOCK_CNT - 1)) begin
            // Block of 64 survived: start a fresh block.
            sh_cnt_n     = '0;
            sh_inv_cnt_n = '0;
          end else begin
            sh_cnt_n = sh_cnt + 7'd1;
            if (!hdr_ok) sh_inv_cnt_n = sh_inv_cnt + 5'd1;
          end
        end
      end
      ST_SLIP: begin
        // tmr counts cycles since slip entry; headers are ignored here.
        if (tmr_inc == TMR_W'(SLIP_LEN)) begin
          state_n      = ST_HUNT;
          tmr_n        = '0;
          bitslip_n    = 1'b0;
          sh_cnt_n     = '0;
          sh_inv_cnt_n = '0;
        end else begin
          tmr_n     = tmr_inc;
          bitslip_n = (tmr_inc < TMR_W'(BITSLIP_HIGH_CYCLES));
        end
      end
      default: state_n = ST_HUNT;
    endcase

    if (enter_slip) begin
      state_n      = ST_SLIP;
      tmr_n        = '0;
      bitslip_n    = 1'b1;
      sh_cnt_n     = '0;
      sh_inv_cnt_n = '0;
      if (slip_cnt == 8'(MAX_SLIPS - 1)) begin
        slip_cnt_n  = '0;
        reset_req_n = 1'b1;
      end else begin
        slip_cnt_n = slip_cnt + 8'd1;
      end
    end
  end

  // BER counting only runs while the lane is, and stays, locked. The beat on
  // the wrap cycle belongs to the closing window before the verdict is taken.
  always_comb begin
    ber_inc = ber_count;
    if ((state == ST_LOCKED) && hdr_valid && !hdr_ok && (ber_count != 5'(BER_LIMIT)))
      ber_inc = ber_count + 5'd1;

    if (state_n != ST_LOCKED) begin
      ber_n      = '0;
      high_ber_n = 1'b0;
    end else if (ber_wrap) begin
      ber_n      = '0;
      high_ber_n = (ber_inc == 5'(BER_LIMIT));
    end else begin
      ber_n      = ber_inc;
      high_ber_n = high_ber | (ber_inc == 5'(BER_LIMIT));
    end
  end

endmodule

// File: rtl/eth_phy_10g_rx_lock_mon.sv
// Multi-lane 64b/66b RX block-lock and BER monitor.
//   clk, rst_n            clock, asynchronous active-low reset
//   serdes_rx_hdr         lane i sync header at [i*2 +: 2]
//   serdes_rx_hdr_valid   per-lane beat qualifier (no backpressure: a beat is
//                         taken on every edge where its bit is 1)
//   serdes_rx_bitslip     per-lane slip request to the SERDES
//   serdes_rx_reset_req   per-lane 1-cycle pulse after MAX_SLIPS failed slips
//   rx_block_lock         per-lane lock
//   rx_high_ber           per-lane high-BER flag
//   rx_ber_count          lane i invalid-header count at [i*5 +: 5]
//   rx_status             rx_block_lock & ~rx_high_ber
//   rx_all_lock           all lanes locked
// Lanes are independent; only the BER window timer is shared.
module eth_phy_10g_rx_lock_mon
  import eth_phy_10g_rx_lock_mon_pkg::*;
#(
  parameter int LANES               = 1,
  parameter int HDR_WIDTH           = 2,
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8,
  parameter int COUNT_125US         = 19531,
  parameter int MAX_SLIPS           = 132
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [LANES*HDR_WIDTH-1:0] serdes_rx_hdr,
  input  logic [LANES-1:0]           serdes_rx_hdr_valid,
  output logic [LANES-1:0]           serdes_rx_bitslip,
  output logic [LANES-1:0]           serdes_rx_reset_req,
  output logic [LANES-1:0]           rx_block_lock,
  output logic [LANES-1:0]           rx_high_ber,
  output logic [LANES*5-1:0]         rx_ber_count,
  output logic [LANES-1:0]           rx_status,
  output logic                       rx_all_lock
);

  localparam int BT_W = $clog2(COUNT_125US);

  logic [BT_W-1:0] ber_tmr;
  logic            ber_wrap;
  lock_state_t     lane_state [LANES];

  assign ber_wrap = (ber_tmr == BT_W'(COUNT_125US - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ber_tmr <= '0;
    else if (ber_wrap) ber_tmr <= '0;
    else               ber_tmr <= ber_tmr + BT_W'(1);
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    eth_phy_10g_rx_lane_lock #(
      .BITSLIP_HIGH_CYCLES (BITSLIP_HIGH_CYCLES),
      .BITSLIP_LOW_CYCLES  (BITSLIP_LOW_CYCLES),
      .MAX_SLIPS           (MAX_SLIPS)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .hdr       (serdes_rx_hdr[i*HDR_WIDTH +: 2]),
      .hdr_valid (serdes_rx_hdr_valid[i]),
      .ber_wrap  (ber_wrap),
      .bitslip   (serdes_rx_bitslip[i]),
      .reset_req (serdes_rx_reset_req[i]),
      .high_ber  (rx_high_ber[i]),
      .ber_count (rx_ber_count[i*5 +: 5]),
      .state_dbg (lane_state[i])
    );

    // Lock is exactly "FSM in LOCKED", so it stays a registered output.
    assign rx_block_lock[i] = (lane_state[i] == ST_LOCKED);
  end

  assign rx_status   = rx_block_lock & ~rx_high_ber;
  assign rx_all_lock = &rx_block_lock;

endmodule

// File: tb/tb_eth_phy_10g_rx_lock_mon.sv
module tb_eth_phy_10g_rx_lock_mon;

  localparam int LANES = 2;
  localparam int COUNT = 200;

  logic             clk;
  logic             rst_n;
  logic [3:0]       serdes_rx_hdr;
  logic [1:0]       serdes_rx_hdr_valid;
  logic [1:0]       serdes_rx_bitslip;
  logic [1:0]       serdes_rx_reset_req;
  logic [1:0]       rx_block_lock;
  logic [1:0]       rx_high_ber;
  logic [9:0]       rx_ber_count;
  logic [1:0]       rx_status;
  logic             rx_all_lock;

  int checks = 0;
  int errors = 0;
  int ec     = 0;  // clock edges since reset release
  logic [0:0] exp_q[$];

  eth_phy_10g_rx_lock_mon #(
    .LANES               (LANES),
    .HDR_WIDTH           (2),
    .BITSLIP_HIGH_CYCLES (1),
    .BITSLIP_LOW_CYCLES  (8),
    .COUNT_125US         (COUNT),
    .MAX_SLIPS           (132)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .serdes_rx_hdr       (serdes_rx_hdr),
    .serdes_rx_hdr_valid (serdes_rx_hdr_valid),
    .serdes_rx_bitslip   (serdes_rx_bitslip),
    .serdes_rx_reset_req (serdes_rx_reset_req),
    .rx_block_lock       (rx_block_lock),
    .rx_high_ber         (rx_high_ber),
    .rx_ber_count        (rx_ber_count),
    .rx_status           (rx_status),
    .rx_all_lock         (rx_all_lock)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, ec, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [1:0] h0, input logic v0, input logic [1:0] h1, input logic v1);
    serdes_rx_hdr       = {h1, h0};
    serdes_rx_hdr_valid = {v1, v0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ec++;
  endtask

  function automatic logic [1:0] good_hdr(input int n);
    return (n % 2 == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic check_all_zero(input string tag);
    check(tag, 32'({serdes_rx_bitslip, serdes_rx_reset_req, rx_block_lock, rx_high_ber,
                    rx_ber_count, rx_status, rx_all_lock}), 32'd0);
  endtask

  // Asserts reset wherever the caller currently is in the cycle and checks
  // the asynchronous clear before any clock edge can arrive.
  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #2;
    check_all_zero(tag);
    drive(2'b00, 1'b0, 2'b00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ec = 0;
  endtask

  task automatic lock_lane0(input int beats);
    for (int b = 0; b < beats; b++) begin
      drive(good_hdr(b), 1'b1, 2'b00, 1'b0);
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(2'b00, 1'b0, 2'b00, 1'b0);
    #3;

    // ---- 1: lane0 locks after 64 valid beats; lane1 slips and requests reset
    apply_reset("reset_outputs");
    check_all_zero("after_reset");
    for (int k = 1; k <= 1320; k++) begin
      drive(good_hdr(k), 1'b1, 2'b00, 1'b1);
      // slip n enters at edge 10n-9: 1 high, 8 low in SLIP, 1 HUNT cycle
      exp_q.push_back(((k - 1) % 10 == 0) ? 1'b1 : 1'b0);
      step();
      check("t1_bitslip1", 32'(serdes_rx_bitslip[1]), 32'(exp_q.pop_front()));
      check("t1_reset_req1", 32'(serdes_rx_reset_req[1]), 32'(k == 1311));
      if (k == 63 || k == 64 || k == 1320) begin
        check("t1_lock0", 32'(rx_block_lock[0]), 32'(k >= 64));
        check("t1_all_lock", 32'(rx_all_lock), 32'd0);
        check("t1_lock1", 32'(rx_block_lock[1]), 32'd0);
      end
    end
    check("t1_status0", 32'(rx_status[0]), 32'd1);
    check("t1_reset_req0", 32'(serdes_rx_reset_req[0]), 32'd0);

    // ---- 2: 15 bad in a block keeps lock, 16 bad drops it
    apply_reset("t2_reset");
    lock_lane0(64);
    check("t2_locked", 32'(rx_block_lock[0]), 32'd1);
    for (int b = 0; b < 64; b++) begin
      drive((b % 4 == 0 && b < 60) ? 2'b11 : good_hdr(b), 1'b1, 2'b00, 1'b0);
      step();
    end
    check("t2_15bad_lock", 32'(rx_block_lock[0]), 32'd1);
    check("t2_15bad_ber", 32'(rx_ber_count[4:0]), 32'd15);
    for (int b = 0; b <= 30; b++) begin
      drive((b % 2 == 0) ? 2'b00 : good_hdr(b), 1'b1, 2'b00, 1'b0);
      step();
      if (b == 0) begin
        check("t2_ber16_high", 32'(rx_high_ber[0]), 32'd1);
        check("t2_ber16_status", 32'(rx_status[0]), 32'd0);
      end
      if (b == 29) check("t2_15th_lock", 32'(rx_block_lock[0]), 32'd1);
    end
    check("t2_16bad_lock", 32'(rx_block_lock[0]), 32'd0);
    check("t2_16bad_slip", 32'(serdes_rx_bitslip[0]), 32'd1);
    check("t2_unlock_ber", 32'({rx_high_ber[0], rx_ber_count[4:0]}), 32'd0);

    // ---- 3/4: BER windows, wrap edges at 200, 400, 600, 800, 1000
    apply_reset("t3_reset");
    for (int e = 1; e <= 1000; e++) begin
      logic bad;
      bad = ((e >= 201) && (e <= 321) && ((e - 201) % 8 == 0)) ||
            (e == 410) || (e == 420) || (e == 430) ||
            ((e >= 680) && (e <= 800) && ((e - 680) % 8 == 0));
      drive(bad ? 2'b00 : good_hdr(e), 1'b1, 2'b11, 1'b0);
      step();
      case (e)
        64:  check("t3_lock", 32'(rx_block_lock[0]), 32'd1);
        313: check("t3_ber15", 32'({rx_high_ber[0], rx_ber_count[4:0]}), 32'd15);
        321: begin
          check("t3_ber16", 32'({rx_high_ber[0], rx_ber_count[4:0]}), 32'h30);
          check("t3_status", 32'(rx_status[0]), 32'd0);
          check("t3_still_locked", 32'(rx_block_lock[0]), 32'd1);
        end
        400: check("t3_wrap_hold", 32'({rx_high_ber[0], rx_ber_count[4:0]}), 32'h20);
        430: check("t3_ber3", 32'({rx_high_ber[0], rx_ber_count[4:0]}), 32'h23);
        599: check("t3_pre_wrap", 32'(rx_high_ber[0]), 32'd1);
        600: begin
          check("t3_clear", 32'({rx_high_ber[0], rx_ber_count[4:0]}), 32'd0);
          check("t3_status_back", 32'(rx_status[0]), 32'd1);
        end
        792: check("t4_ber15", 32'({rx_high_ber[0], rx_ber_count[4:0]}), 32'd15);
        800: check("t4_wrap_set", 32'({rx_high_ber[0], rx_ber_count[4:0]}), 32'h20);
        999: check("t4_held", 32'(rx_high_ber[0]), 32'd1);
        1000: check("t4_clear", 32'(rx_high_ber[0]), 32'd0);
        default: ;
      endcase
    end
    check("t3_lane1_frozen", 32'({rx_block_lock[1], serdes_rx_bitslip[1]}), 32'd0);

    // ---- 5: lock counts valid beats, not cycles
    apply_reset("t5_reset");
    for (int e = 1; e <= 127; e++) begin
      drive(good_hdr(e), (e % 2 == 1), 2'b00, 1'b0);
      step();
      if (e == 126) check("t5_not_yet", 32'(rx_block_lock[0]), 32'd0);
    end
    check("t5_lock64", 32'(rx_block_lock[0]), 32'd1);
    check("t5_lane1_idle", 32'(serdes_rx_bitslip[1]), 32'd0);

    // ---- 6: reset mid-slip and while locked, then re-hunt
    apply_reset("t6_reset");
    lock_lane0(64);
    drive(good_hdr(64), 1'b1, 2'b00, 1'b1);
    step();
    check("t6_slip_high", 32'(serdes_rx_bitslip[1]), 32'd1);
    check("t6_lock_before", 32'(rx_block_lock[0]), 32'd1);
    #2;
    apply_reset("t6_async_clear");
    check_all_zero("t6_after_release");
    for (int b = 0; b < 64; b++) begin
      drive(good_hdr(b), 1'b1, 2'b00, 1'b0);
      step();
      if (b == 62) check("t6_rehunt_63", 32'(rx_block_lock[0]), 32'd0);
    end
    check("t6_relock", 32'(rx_block_lock[0]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
